// File: rtl/jtag_reg_master.sv
`default_nettype none
// jtag_reg_master: JTAG initiator that turns register read/write requests into
// USER1 DR scans of 38-bit checksummed frames.
module jtag_reg_master #(
  parameter int                CLK_DIV = 4,
  parameter int                IR_LEN  = 6,
  parameter logic [IR_LEN-1:0] USER_IR = 6'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [5:0]  IR_FIRST  = 6'd10;
  localparam logic [5:0]  IR_LAST   = 6'(10 + IR_LEN - 1);
  localparam logic [5:0]  INIT_LAST = 6'(11 + IR_LEN);
  localparam logic [5:0]  SH_FIRST  = 6'd3;
  localparam logic [5:0]  SH_LAST   = 6'd40;
  localparam logic [5:0]  CAP_LAST  = 6'd34;
  localparam logic [5:0]  DR_LAST   = 6'd42;

  state_t      state;
  logic [5:0]  bit_idx;
  logic [15:0] div_cnt;
  logic        we_q;
  logic [3:0]  addr_q;
  logic [31:0] data_q;
  logic        pass;
  logic [31:0] cap;

  logic [36:0] body;
  logic [37:0] frame;
  logic [5:0]  nxt_idx;
  logic [5:0]  shift_k;
  logic        nxt_tms;
  logic        nxt_tdi;

  assign body  = {we_q, addr_q, data_q};
  assign frame = {~^body, body};

  // TMS/TDI for the TCK cycle that follows the current one.
  always_comb begin
    nxt_idx = bit_idx + 6'd1;
    shift_k = nxt_idx - SH_FIRST;
    nxt_tms = 1'b0;
    nxt_tdi = 1'b0;
    if (state == S_INIT) begin
      if (nxt_idx < 6'd5 || nxt_idx == 6'd6 || nxt_idx == 6'd7) begin
        nxt_tms = 1'b1;
      end else if (nxt_idx >= IR_FIRST && nxt_idx <= IR_LAST) begin
        nxt_tms = (nxt_idx == IR_LAST);
        nxt_tdi = |(USER_IR & (IR_LEN'(1) << (nxt_idx - IR_FIRST)));
      end else if (nxt_idx == IR_LAST + 6'd1) begin
        nxt_tms = 1'b1;
      end
    end else begin
      if (nxt_idx >= SH_FIRST && nxt_idx <= SH_LAST) begin
        nxt_tms = (nxt_idx == SH_LAST);
        nxt_tdi = frame[shift_k];
      end else if (nxt_idx == SH_LAST + 6'd1) begin
        nxt_tms = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      bit_idx   <= '0;
      div_cnt   <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      pass      <= 1'b0;
      cap       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            data_q    <= req_we ? req_wdata : 32'd0;
            req_ready <= 1'b0;
            state     <= S_SCAN;
            bit_idx   <= '0;
            div_cnt   <= '0;
            pass      <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
          end
        end
        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (!tck) begin
              tck <= 1'b1;
              // Only data bits [31:0] are kept; they leave the shifter LSB first.
              if (state == S_SCAN && bit_idx >= SH_FIRST && bit_idx <= CAP_LAST)
                cap <= {tdo, cap[31:1]};
            end else begin
              tck <= 1'b0;
              if (state == S_INIT && bit_idx == INIT_LAST) begin
                state     <= S_IDLE;
                bit_idx   <= '0;
                req_ready <= 1'b1;
                tms       <= 1'b0;
                tdi       <= 1'b0;
              end else if (state == S_SCAN && bit_idx == DR_LAST) begin
                bit_idx <= '0;
                if (!we_q && !pass) begin
                  // Reads need a second scan to bring back the addressed data.
                  pass <= 1'b1;
                  tms  <= 1'b1;
                  tdi  <= 1'b0;
                end else begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= we_q ? 32'd0 : cap;
                  tms       <= 1'b0;
                  tdi       <= 1'b0;
                end
              end else begin
                bit_idx <= nxt_idx;
                tms     <= nxt_tms;
                tdi     <= nxt_tdi;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
